// File: rtl/iq_demux_w_fifo.sv
// IQ demultiplexer: splits an interleaved I/Q word stream into two output FIFOs.
// Optional Q10 gain on the input path is enabled with macro IQ_DEMUX_GAIN_EN.

module iq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  // First-word-fall-through: the head word is always visible on dout.
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module iq_demux_w_fifo #(
  parameter int                 FIFO_BUFFER_SIZE = 256,
  parameter logic signed [31:0] GAIN             = 32'sd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [31:0] out_i,
  output logic        out_i_empty,
  input  logic        out_i_rd_en,
  output logic [31:0] out_q,
  output logic        out_q_empty,
  input  logic        out_q_rd_en
);
  typedef enum logic {READ, WRITE} state_t;

  state_t      state;
  logic        sel;
  logic [31:0] hold;
  logic [31:0] processed;
  logic        full_i;
  logic        full_q;
  logic        wr_i;
  logic        wr_q;
  logic        sel_full;

`ifdef IQ_DEMUX_GAIN_EN
  logic signed [63:0] product;
  assign product   = $signed({{32{in[31]}}, in}) * $signed({{32{GAIN[31]}}, GAIN});
  // Arithmetic shift by 10 then truncate: bits [41:10] of the product.
  assign processed = product[41:10];
`else
  assign processed = in;
`endif

  assign sel_full = sel ? full_q : full_i;
  assign in_rd_en = !reset && (state == READ) && !in_empty;
  assign wr_i     = (state == WRITE) && !sel && !full_i;
  assign wr_q     = (state == WRITE) &&  sel && !full_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= READ;
      sel   <= 1'b0;
      hold  <= '0;
    end else begin
      case (state)
        READ: begin
          if (!in_empty) begin
            hold  <= processed;
            state <= WRITE;
          end
        end
        WRITE: begin
          // Only the FIFO currently selected can stall the block.
          if (!sel_full) begin
            sel   <= ~sel;
            state <= READ;
          end
        end
        default: state <= READ;
      endcase
    end
  end

  iq_fifo #(.WIDTH(32), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_i (
    .clock (clock),
    .reset (reset),
    .wr_en (wr_i),
    .din   (hold),
    .full  (full_i),
    .rd_en (out_i_rd_en),
    .dout  (out_i),
    .empty (out_i_empty)
  );

  iq_fifo #(.WIDTH(32), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_q (
    .clock (clock),
    .reset (reset),
    .wr_en (wr_q),
    .din   (hold),
    .full  (full_q),
    .rd_en (out_q_rd_en),
    .dout  (out_q),
    .empty (out_q_empty)
  );
endmodule

// File: tb/tb_iq_demux_w_fifo.sv
// Bench for iq_demux_w_fifo: queue-based reference model plus directed and random stimulus.
// Define IQ_DEMUX_GAIN_EN for both bench and RTL to cover the gain build.

module tb_iq_demux_w_fifo;
  localparam int                 DEPTH  = 4;
  localparam logic signed [31:0] GAIN_T = 32'sd512;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_w;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out_i;
  logic        out_i_empty;
  logic        out_i_rd_en;
  logic [31:0] out_q;
  logic        out_q_empty;
  logic        out_q_rd_en;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] up[$];
  logic [31:0] mi[$];
  logic [31:0] mq[$];
  bit          pend = 0;
  logic [31:0] pend_w;
  bit          msel = 0;
  int          accepted = 0;
  logic        prev_rd = 1'b0;

  iq_demux_w_fifo #(.FIFO_BUFFER_SIZE(DEPTH), .GAIN(GAIN_T)) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in_w),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .out_i       (out_i),
    .out_i_empty (out_i_empty),
    .out_i_rd_en (out_i_rd_en),
    .out_q       (out_q),
    .out_q_empty (out_q_empty),
    .out_q_rd_en (out_q_rd_en)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] proc(input logic [31:0] x);
`ifdef IQ_DEMUX_GAIN_EN
    longint p;
    p = longint'($signed(x)) * longint'(GAIN_T);
    return 32'(p >>> 10);
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word taken from upstream is delivered to its FIFO one edge later,
  // unless that FIFO is full; the k-th word goes to I for even k, Q for odd k.
  always @(posedge clock) begin
    if (reset) begin
      mi.delete();
      mq.delete();
      pend = 0;
      msel = 0;
    end else begin
      bit fi, fq;
      fi = (mi.size() >= DEPTH);
      fq = (mq.size() >= DEPTH);
      if (out_i_rd_en && mi.size() > 0) void'(mi.pop_front());
      if (out_q_rd_en && mq.size() > 0) void'(mq.pop_front());
      if (pend) begin
        if (!msel && !fi) begin
          mi.push_back(pend_w); pend = 0; msel = 1;
        end else if (msel && !fq) begin
          mq.push_back(pend_w); pend = 0; msel = 0;
        end
      end else if (!in_empty) begin
        pend_w = proc(in_w);
        pend   = 1;
        accepted++;
        if (up.size() > 0) void'(up.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    chk("in_rd_en", {31'b0, in_rd_en}, {31'b0, !reset && !pend && !in_empty});
    chk("in_rd_en back-to-back", {31'b0, in_rd_en & prev_rd}, 32'd0);
    prev_rd <= in_rd_en;
    chk("out_i_empty", {31'b0, out_i_empty}, {31'b0, mi.size() == 0});
    chk("out_q_empty", {31'b0, out_q_empty}, {31'b0, mq.size() == 0});
    if (mi.size() > 0) chk("out_i head", out_i, mi[0]);
    if (mq.size() > 0) chk("out_q head", out_q, mq[0]);
  end

  // Upstream FWFT source presented from the bench queue.
  always @(negedge clock) begin
    #2;
    in_empty = (up.size() == 0);
    in_w     = (up.size() > 0) ? up[0] : 32'hDEAD_BEEF;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((up.size() > 0 || pend) && n < max) begin
      tick();
      n++;
    end
    chk("wait_idle timeout", {31'b0, n >= max}, 32'd0);
    tick();
  endtask

  task automatic pop_i_exp(input string nm, input logic [31:0] x);
    int n = 0;
    while (out_i_empty && n < 60) begin tick(); n++; end
    chk(nm, out_i, x);
    out_i_rd_en = 1'b1;
    tick();
    out_i_rd_en = 1'b0;
  endtask

  task automatic pop_q_exp(input string nm, input logic [31:0] x);
    int n = 0;
    while (out_q_empty && n < 60) begin tick(); n++; end
    chk(nm, out_q, x);
    out_q_rd_en = 1'b1;
    tick();
    out_q_rd_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    up.delete();
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_empty = 1'b1; in_w = '0;
    out_i_rd_en = 1'b0; out_q_rd_en = 1'b0;
    tick(3);
    reset = 1'b0;
    tick();
    chk("reset out_i_empty", {31'b0, out_i_empty}, 32'd1);
    chk("reset out_q_empty", {31'b0, out_q_empty}, 32'd1);
    chk("reset in_rd_en", {31'b0, in_rd_en}, 32'd0);

    // basic alternation, no downstream pops
    for (int v = 1; v <= 6; v++) up.push_back(32'(v));
    wait_idle(60);
    pop_i_exp("basic i0", proc(32'd1));
    pop_i_exp("basic i1", proc(32'd3));
    pop_i_exp("basic i2", proc(32'd5));
    pop_q_exp("basic q0", proc(32'd2));
    pop_q_exp("basic q1", proc(32'd4));
    pop_q_exp("basic q2", proc(32'd6));

    // Q FIFO fills; word 9 is held until a Q pop
    for (int v = 0; v < 12; v++) up.push_back(32'(v));
    out_i_rd_en = 1'b1;
    tick(40);
    chk("stall upstream remaining", 32'(up.size()), 32'd2);
    chk("stall in_rd_en", {31'b0, in_rd_en}, 32'd0);
    chk("stall pending word", pend_w, proc(32'd9));
    chk("stall out_q head", out_q, proc(32'd1));
    pop_q_exp("stall q1", proc(32'd1));
    pop_q_exp("stall q3", proc(32'd3));
    pop_q_exp("stall q5", proc(32'd5));
    pop_q_exp("stall q7", proc(32'd7));
    pop_q_exp("stall q9", proc(32'd9));
    pop_q_exp("stall q11", proc(32'd11));
    out_i_rd_en = 1'b0;
    wait_idle(60);

    // reset mid-operation with a held word
    begin
      int base, n;
      base = accepted;
      n = 0;
      for (int v = 16; v < 20; v++) up.push_back(32'(v));
      while (accepted < base + 3 && n < 60) begin tick(); n++; end
      chk("mid reset accept timeout", {31'b0, n >= 60}, 32'd0);
    end
    reset = 1'b1;
    up.delete();
    tick(2);
    chk("mid reset out_i_empty", {31'b0, out_i_empty}, 32'd1);
    chk("mid reset out_q_empty", {31'b0, out_q_empty}, 32'd1);
    reset = 1'b0;
    tick();
    up.push_back(32'hA);
    up.push_back(32'hB);
    pop_i_exp("post reset i", proc(32'hA));
    pop_q_exp("post reset q", proc(32'hB));

    // long idle upstream
    for (int c = 0; c < 20; c++) begin
      chk("idle in_rd_en", {31'b0, in_rd_en}, 32'd0);
      tick();
    end
    up.push_back(32'h7);
    up.push_back(32'h8);
    pop_i_exp("idle then i", proc(32'h7));
    pop_q_exp("idle then q", proc(32'h8));

`ifdef IQ_DEMUX_GAIN_EN
    up.push_back(32'h0000_0400);
    up.push_back(32'hFFFF_FC00);
    up.push_back(32'h0000_0003);
    pop_i_exp("gain i0", 32'h0000_0200);
    pop_q_exp("gain q0", 32'hFFFF_FE00);
    pop_i_exp("gain i1", 32'h0000_0001);
    wait_idle(60);
`endif
    pulse_reset();

    // pop out_i on the same edge a new I word is written
    up.push_back(32'h21);
    wait_idle(60);
    up.push_back(32'h22);
    wait_idle(60);
    up.push_back(32'h23);
    tick();
    out_i_rd_en = 1'b1;
    tick();
    out_i_rd_en = 1'b0;
    chk("simul pop/write out_i_empty", {31'b0, out_i_empty}, 32'd0);
    chk("simul pop/write out_i", out_i, proc(32'h23));
    pop_q_exp("simul q", proc(32'h22));
    pop_i_exp("simul i", proc(32'h23));

    // random traffic with backpressure and upstream gaps
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0 && up.size() < 8) up.push_back($urandom);
      out_i_rd_en = ($urandom_range(0, 2) == 0);
      out_q_rd_en = ($urandom_range(0, 3) == 0);
      tick();
    end
    out_i_rd_en = 1'b1;
    out_q_rd_en = 1'b1;
    wait_idle(200);
    tick(2 * DEPTH + 4);
    chk("drain out_i_empty", {31'b0, out_i_empty}, 32'd1);
    chk("drain out_q_empty", {31'b0, out_q_empty}, 32'd1);
    out_i_rd_en = 1'b0;
    out_q_rd_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/iq_demux_w_fifo.md
IQ_DEMUX_W_FIFO -- requirements
Module: iq_demux_w_fifo

Interface
REQ-001 Parameter FIFO_BUFFER_SIZE, default 256: depth of each internal output FIFO, in words.
REQ-002 Parameter GAIN, default 1024: signed 32-bit Q10 gain; 1024 = 1.0; used only when IQ_DEMUX_GAIN_EN is defined.
REQ-003 Port clock, input, 1: sole clock; all flops and both FIFO read/write clocks run on it.
REQ-004 Port reset, input, 1: asynchronous, active-high.
REQ-005 Port in, input, 32: interleaved signed sample stream I0,Q0,I1,Q1,...; valid whenever in_empty=0 (first-word-fall-through).
REQ-006 Port in_empty, input, 1: upstream FIFO empty flag.
REQ-007 Port in_rd_en, output, 1: pops one word from the upstream FIFO.
REQ-008 Port out_i, output, 32: head of the I output FIFO.
REQ-009 Port out_i_empty, output, 1: I output FIFO empty flag.
REQ-010 Port out_i_rd_en, input, 1: pops the I output FIFO.
REQ-011 Ports out_q (output, 32), out_q_empty (output, 1) and out_q_rd_en (input, 1) SHALL behave identically for the Q path.

Function
REQ-012 The block SHALL contain two instances of the team fifo: data width 32, depth FIFO_BUFFER_SIZE, both sides on clock, both reset by reset.
REQ-013 The FSM SHALL have two states, READ and WRITE, plus a 1-bit select flag (0 = I, 1 = Q) and a 32-bit holding register.
REQ-014 In READ with in_empty=0, the block SHALL assert in_rd_en for exactly that cycle, load the holding register with the processed value of in, and go to WRITE.
REQ-015 In READ with in_empty=1, the block SHALL keep in_rd_en=0 and stay in READ.
REQ-016 In WRITE, if the FIFO chosen by select is not full, the block SHALL assert that FIFO's wr_en with din equal to the holding register, toggle select, and go to READ.
REQ-017 In WRITE, if the chosen FIFO is full, the block SHALL deassert all write enables, keep in_rd_en=0, and stay in WRITE; the holding register and select SHALL be unchanged.
REQ-018 Fullness of the non-selected FIFO SHALL NOT stall the block.
REQ-019 in_rd_en SHALL never be asserted outside READ; the write enables SHALL never be asserted outside WRITE.
REQ-020 Peak throughput SHALL be one input word per two cycles: a word accepted in cycle t is written into its output FIFO at the edge ending cycle t+1 when that FIFO is not full.
REQ-021 Routing SHALL strictly alternate: the k-th accepted word (k = 0, 1, 2, ...) goes to I if k is even and to Q if k is odd, with no loss, duplication or reordering.
REQ-022 Downstream pops SHALL be independent of the FSM and may coincide with writes to the same FIFO.

Reset
REQ-023 On reset: state = READ, select = I, holding register = 0, in_rd_en = 0, all write enables = 0.
REQ-024 On reset, both output FIFOs SHALL be emptied, giving out_i_empty = 1 and out_q_empty = 1.
REQ-025 Reset asserted mid-operation SHALL discard any held word; the first word accepted after release SHALL go to I.

Configuration
REQ-026 Macro IQ_DEMUX_GAIN_EN: when defined, the processed value SHALL be the signed 64-bit product in*GAIN, arithmetically shifted right by 10 (floor), truncated to 32 bits.
REQ-027 When IQ_DEMUX_GAIN_EN is undefined, the processed value SHALL equal in exactly, and GAIN SHALL be ignored.

Verification
REQ-028 Push 1,2,3,4,5,6 with no downstream pops -> out_i pops 1,3,5; out_q pops 2,4,6; in_rd_en is never high on two consecutive cycles.
REQ-029 FIFO_BUFFER_SIZE=4; push 12 words with out_q_rd_en=0 -> block stalls in WRITE holding word 9 (the 5th Q word); after one Q pop, word 9 enters the Q FIFO and flow resumes in order.
REQ-030 Assert reset after 3 words have been accepted -> both empty flags are 1 after reset; next push 0xA then 0xB -> 0xA appears on out_i and 0xB on out_q.
REQ-031 Hold in_empty=1 for 20 cycles, then present 0x7 -> in_rd_en stays 0 for those 20 cycles, then 0x7 appears on out_i.
REQ-032 IQ_DEMUX_GAIN_EN defined, GAIN=512; push 0x00000400, 0xFFFFFC00, 0x00000003 -> out_i receives 0x00000200 and 0x00000001; out_q receives 0xFFFFFE00.
REQ-033 Pop out_i on the same cycle a new I word is written, with out_i holding one word -> no word is lost, and out_i_empty does not glitch high.
